// File: rtl/m_controller_pkg.sv
// m_controller_pkg: mux/result encodings, funct3 codes and FSM states shared by the M-unit controller
package m_controller_pkg;
    localparam int MUX_MULTA_LENGTH  = 2;
    localparam int MUX_MULTB_LENGTH  = 2;
    localparam int MUX_R_LENGTH      = 3;
    localparam int MUX_D_LENGTH      = 2;
    localparam int MUX_Z_LENGTH      = 2;
    localparam int RESULT_SEL_LENGTH = 2;

    localparam logic [1:0] MULTA_ZERO = 2'd0, MULTA_UNSIGNED = 2'd1, MULTA_SIGNED = 2'd2;
    localparam logic [1:0] MULTB_ZERO = 2'd0, MULTB_UNSIGNED = 2'd1, MULTB_SIGNED = 2'd2;
    localparam logic [2:0] R_KEEP = 3'd0, R_A = 3'd1, R_A_NEG = 3'd2, R_SUB_KEEP = 3'd3, R_MULT_LOWER = 3'd4;
    localparam logic [1:0] D_KEEP = 2'd0, D_B = 2'd1, D_B_NEG = 2'd2, D_SHR = 2'd3;
    localparam logic [1:0] Z_KEEP = 2'd0, Z_ZERO = 2'd1, Z_SHL_ADD = 2'd2, Z_MULT_UPPER = 2'd3;
    localparam logic [1:0] RES_Z = 2'd0, RES_R = 2'd1, RES_ONES = 2'd2;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    localparam logic [2:0] S_IDLE = 3'd0, S_MUL_OP = 3'd1, S_MUL_WAIT = 3'd2, S_MUL_CAPT = 3'd3;
    localparam logic [2:0] S_DIV_ITER = 3'd4, S_DONE = 3'd5;

    function automatic logic signed_div(input logic [2:0] f3);
        return f3 == F_DIV || f3 == F_REM;
    endfunction
endpackage

// File: rtl/m_controller_if.sv
// m_controller_if: handshake, operand flags and datapath selects between pipeline and M-unit controller
interface m_controller_if;
    import m_controller_pkg::*;
    logic flush, valid, ready;
    logic [2:0] funct3;
    logic rs1_sign, rs2_sign, rs2_zero, sub_neg;
    logic [MUX_MULTA_LENGTH-1:0] mux_multA;
    logic [MUX_MULTB_LENGTH-1:0] mux_multB;
    logic [MUX_R_LENGTH-1:0] mux_R;
    logic [MUX_D_LENGTH-1:0] mux_D;
    logic [MUX_Z_LENGTH-1:0] mux_Z;
    logic done, result_neg;
    logic [RESULT_SEL_LENGTH-1:0] result_sel;
    modport master(output flush, valid, funct3, rs1_sign, rs2_sign, rs2_zero, sub_neg,
                   input ready, mux_multA, mux_multB, mux_R, mux_D, mux_Z, done, result_sel, result_neg);
    modport slave(input flush, valid, funct3, rs1_sign, rs2_sign, rs2_zero, sub_neg,
                  output ready, mux_multA, mux_multB, mux_R, mux_D, mux_Z, done, result_sel, result_neg);
endinterface

// File: rtl/m_step_counter.sv
// m_step_counter: 5-bit step counter with clear/enable and terminal-count flag
module m_step_counter #(
    parameter int STEPS = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic       en,
    output logic [4:0] cnt,
    output logic       tc
);
    assign tc = cnt == 5'(STEPS - 1);
    always_ff @(posedge clk or posedge resetn)
        if (resetn) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 5'd1;
endmodule

// File: rtl/m_controller.sv
// m_controller: RV32M sequencing FSM; define M_DIV_ZERO_BYPASS_EN to finish division by zero in one cycle
module m_controller
    import m_controller_pkg::*;
#(
    parameter int MULT_LATENCY = 0,
    parameter int DIV_STEPS    = 32
) (
    input logic clk,
    input logic resetn,
    m_controller_if.slave bus
);
    logic [2:0] state, state_n, op;
    logic [4:0] cnt;
    logic s1, s2, z2, accept, tc, wait_end, byp_in, byp_q, in_mul, iter, capt;

    assign accept   = state == S_IDLE && bus.valid && !bus.flush;
    assign wait_end = state == S_MUL_WAIT && cnt == 5'(MULT_LATENCY);
    assign in_mul   = state == S_MUL_OP || state == S_MUL_WAIT || state == S_MUL_CAPT;
    assign iter     = state == S_DIV_ITER;
    assign capt     = state == S_MUL_CAPT;
`ifdef M_DIV_ZERO_BYPASS_EN
    assign byp_in = bus.funct3[2] && bus.rs2_zero;
    assign byp_q  = op[2] && z2;
`else
    assign byp_in = 1'b0;
    assign byp_q  = 1'b0;
`endif

    m_step_counter #(.STEPS(DIV_STEPS)) u_cnt (
        .clk(clk), .resetn(resetn), .clr(accept || wait_end || bus.flush),
        .en(iter || state == S_MUL_WAIT), .cnt(cnt), .tc(tc)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:     if (accept) state_n = byp_in ? S_DONE : bus.funct3[2] ? S_DIV_ITER : S_MUL_OP;
            S_MUL_OP:   state_n = S_MUL_WAIT;
            S_MUL_WAIT: if (wait_end) state_n = S_MUL_CAPT;
            S_MUL_CAPT: state_n = S_DONE;
            S_DIV_ITER: if (tc) state_n = S_DONE;
            default:    state_n = S_IDLE;
        endcase
        if (bus.flush) state_n = S_IDLE;
    end

    always_ff @(posedge clk or posedge resetn)
        if (resetn) begin
            state <= S_IDLE;
            op    <= '0;
            s1    <= 1'b0;
            s2    <= 1'b0;
            z2    <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                op <= bus.funct3;
                s1 <= bus.rs1_sign;
                s2 <= bus.rs2_sign;
                z2 <= bus.rs2_zero;
            end
        end

    // multiplier selects stay stable through capture so the upper word is extracted with the right signedness
    assign bus.mux_multA = !in_mul ? MULTA_ZERO : (op == F_MULH || op == F_MULHSU) ? MULTA_SIGNED : MULTA_UNSIGNED;
    assign bus.mux_multB = !in_mul ? MULTB_ZERO : op == F_MULH ? MULTB_SIGNED : MULTB_UNSIGNED;
    assign bus.mux_R = accept ? (!byp_in && signed_div(bus.funct3) && bus.rs1_sign ? R_A_NEG : R_A)
                     : iter ? R_SUB_KEEP : capt ? R_MULT_LOWER : R_KEEP;
    assign bus.mux_D = accept ? (signed_div(bus.funct3) && bus.rs2_sign ? D_B_NEG : D_B)
                     : iter ? D_SHR : D_KEEP;
    assign bus.mux_Z = accept && bus.funct3[2] ? Z_ZERO : iter ? Z_SHL_ADD : capt ? Z_MULT_UPPER : Z_KEEP;
    assign bus.ready = state == S_IDLE;
    assign bus.done  = state == S_DONE && !bus.flush;
    assign bus.result_sel = state != S_DONE ? RES_Z : byp_q && !op[1] ? RES_ONES
                          : (op == F_MUL || op[2:1] == 2'b11) ? RES_R : RES_Z;
    assign bus.result_neg = state == S_DONE && !byp_q && (op == F_DIV ? (s1 ^ s2) && !z2 : op == F_REM && s1);
endmodule

// File: tb/tb_m_controller.sv
module tb_m_controller;
    import m_controller_pkg::*;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    int n_vec = 0;
    int n_err = 0;
`ifdef M_DIV_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    m_controller_if bus();
    m_controller dut(.clk(clk), .resetn(resetn), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [2:0] f3, input logic a_s, input logic b_s, input logic b_z);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.funct3 = f3;
        bus.rs1_sign = a_s;
        bus.rs2_sign = b_s;
        bus.rs2_zero = b_z;
        #1;
    endtask

    task automatic tick;
        @(negedge clk);
        bus.valid = 1'b0;
        #1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic a_s, input logic b_s, input logic b_z,
                          input logic [2:0] er0, input logic [1:0] ed0, input logic [1:0] ez0,
                          input logic [1:0] ema, input logic [1:0] emb, input logic [2:0] er1,
                          input int elat, input logic [1:0] esel, input logic eneg);
        int lat = 0;
        start(f3, a_s, b_s, b_z);
        check({tag, ".ready"}, 32'(bus.ready), 32'd1);
        check({tag, ".acc_R"}, 32'(bus.mux_R), 32'(er0));
        check({tag, ".acc_D"}, 32'(bus.mux_D), 32'(ed0));
        check({tag, ".acc_Z"}, 32'(bus.mux_Z), 32'(ez0));
        do begin
            tick();
            lat++;
            if (lat == 1) begin
                check({tag, ".multA"}, 32'(bus.mux_multA), 32'(ema));
                check({tag, ".multB"}, 32'(bus.mux_multB), 32'(emb));
                check({tag, ".R1"}, 32'(bus.mux_R), 32'(er1));
            end
            if (!f3[2] && lat == 3) begin
                check({tag, ".capt_multA"}, 32'(bus.mux_multA), 32'(ema));
                check({tag, ".capt_R"}, 32'(bus.mux_R), 32'(R_MULT_LOWER));
                check({tag, ".capt_Z"}, 32'(bus.mux_Z), 32'(Z_MULT_UPPER));
            end
        end while (!bus.done && lat < 60);
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".sel"}, 32'(bus.result_sel), 32'(esel));
        check({tag, ".neg"}, 32'(bus.result_neg), 32'(eneg));
    endtask

    initial begin
        int dcnt;
        bus.flush = 1'b0;
        bus.valid = 1'b0;
        bus.funct3 = '0;
        bus.rs1_sign = 1'b0;
        bus.rs2_sign = 1'b0;
        bus.rs2_zero = 1'b0;
        bus.sub_neg = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst.ready", 32'(bus.ready), 32'd1);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.sel", 32'(bus.result_sel), 32'(RES_Z));
        check("rst.R", 32'(bus.mux_R), 32'(R_KEEP));
        check("rst.multA", 32'(bus.mux_multA), 32'(MULTA_ZERO));
        @(negedge clk);
        resetn = 1'b0;

        // MUL 7 * -3 family: selects fixed by funct3, done 4 cycles after accept
        run_op("mul",    F_MUL,    0, 1, 0, R_A, D_B, Z_KEEP, MULTA_UNSIGNED, MULTB_UNSIGNED, R_KEEP, 4, RES_R, 0);
        run_op("mulh",   F_MULH,   0, 1, 0, R_A, D_B, Z_KEEP, MULTA_SIGNED,   MULTB_SIGNED,   R_KEEP, 4, RES_Z, 0);
        run_op("mulhu",  F_MULHU,  0, 1, 0, R_A, D_B, Z_KEEP, MULTA_UNSIGNED, MULTB_UNSIGNED, R_KEEP, 4, RES_Z, 0);
        run_op("mulhsu", F_MULHSU, 1, 1, 0, R_A, D_B, Z_KEEP, MULTA_SIGNED,   MULTB_UNSIGNED, R_KEEP, 4, RES_Z, 0);
        // -7 / 2 and -7 % 2
        run_op("div_n7_2", F_DIV, 1, 0, 0, R_A_NEG, D_B, Z_ZERO, MULTA_ZERO, MULTB_ZERO, R_SUB_KEEP, 33, RES_Z, 1);
        run_op("rem_n7_2", F_REM, 1, 0, 0, R_A_NEG, D_B, Z_ZERO, MULTA_ZERO, MULTB_ZERO, R_SUB_KEEP, 33, RES_R, 1);
        // divide by zero
        run_op("divu_z", F_DIVU, 0, 0, 1, R_A, D_B, Z_ZERO, MULTA_ZERO, MULTB_ZERO, BYP ? R_KEEP : R_SUB_KEEP,
               BYP ? 1 : 33, BYP ? RES_ONES : RES_Z, 0);
        run_op("div_z", F_DIV, 1, 0, 1, BYP ? R_A : R_A_NEG, D_B, Z_ZERO, MULTA_ZERO, MULTB_ZERO,
               BYP ? R_KEEP : R_SUB_KEEP, BYP ? 1 : 33, BYP ? RES_ONES : RES_Z, 0);
        run_op("remu_z", F_REMU, 1, 0, 1, R_A, D_B, Z_ZERO, MULTA_ZERO, MULTB_ZERO, BYP ? R_KEEP : R_SUB_KEEP,
               BYP ? 1 : 33, RES_R, 0);
        // 0x80000000 / -1 overflow case
        run_op("div_ovf", F_DIV, 1, 1, 0, R_A_NEG, D_B_NEG, Z_ZERO, MULTA_ZERO, MULTB_ZERO, R_SUB_KEEP, 33, RES_Z, 0);
        run_op("rem_ovf", F_REM, 1, 1, 0, R_A_NEG, D_B_NEG, Z_ZERO, MULTA_ZERO, MULTB_ZERO, R_SUB_KEEP, 33, RES_R, 1);

        // flush at iteration step 10
        start(F_DIV, 1, 0, 0);
        repeat (11) tick();
        check("flush.in_iter", 32'(bus.mux_D), 32'(D_SHR));
        bus.flush = 1'b1;
        #1;
        check("flush.done", 32'(bus.done), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush.ready", 32'(bus.ready), 32'd1);
        check("flush.no_done", 32'(bus.done), 32'd0);
        run_op("post_flush_mulhu", F_MULHU, 0, 0, 0, R_A, D_B, Z_KEEP, MULTA_UNSIGNED, MULTB_UNSIGNED, R_KEEP, 4, RES_Z, 0);

        // valid together with flush in IDLE is ignored
        @(negedge clk);
        bus.valid = 1'b1;
        bus.flush = 1'b1;
        bus.funct3 = F_MUL;
        #1;
        check("idle_flush.R", 32'(bus.mux_R), 32'(R_KEEP));
        @(negedge clk);
        bus.valid = 1'b0;
        bus.flush = 1'b0;
        #1;
        check("idle_flush.ready", 32'(bus.ready), 32'd1);

        // asynchronous reset while waiting on the multiplier
        start(F_MUL, 0, 0, 0);
        tick();
        tick();
        check("arst.pre_multA", 32'(bus.mux_multA), 32'(MULTA_UNSIGNED));
        resetn = 1'b1;
        #1;
        check("arst.ready", 32'(bus.ready), 32'd1);
        check("arst.multA", 32'(bus.mux_multA), 32'(MULTA_ZERO));
        check("arst.done", 32'(bus.done), 32'd0);
        @(negedge clk);
        resetn = 1'b0;
        dcnt = 0;
        repeat (8) begin
            tick();
            if (bus.done) dcnt++;
        end
        check("arst.no_done", 32'(dcnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/m_controller.md
Name: m_controller

Overview:
Sequencing FSM for the M-extension unit; the control end of the remainder/divisor/quotient/multiplier-operand register datapath.
- Accepts one RV32M op per handshake.
- Drives every datapath mux select and consumes the datapath's subtractor sign flag.
- Signals completion and tells the result stage which register to forward and whether to negate it.
- Handles MUL/MULH/MULHSU/MULHU via the registered multiplier, and DIV/DIVU/REM/REMU via 32-step restoring division.

Parameters:
MULT_LATENCY, 0, cycles from mult_a/mult_b update to valid product at the datapath's P input (0 = combinational multiplier)
DIV_STEPS, 32, restoring-division iterations (fixed for RV32; not intended to be changed)

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-high (asserted = 1)
flush  in  1  pipeline kill; aborts any op
valid  in  1  op request
ready  out  1  controller idle, can accept
funct3  in  3  RV32M funct3 (000 MUL … 111 REMU)
rs1_sign  in  1  rs1[31]
rs2_sign  in  1  rs2[31]
rs2_zero  in  1  rs2 == 0
sub_neg  in  1  datapath subtract result negative (R < D)
mux_multA  out  `MUX_MULTA_LENGTH  multiplier A select
mux_multB  out  `MUX_MULTB_LENGTH  multiplier B select
mux_R  out  `MUX_R_LENGTH  remainder register select
mux_D  out  `MUX_D_LENGTH  divisor register select
mux_Z  out  `MUX_Z_LENGTH  quotient register select
done  out  1  one-cycle result-valid pulse
result_sel  out  2  RES_Z, RES_R or RES_ONES
result_neg  out  1  result stage must two's-complement the selected value

Behaviour:
- Reset (async, resetn=1):
  - state IDLE, step counter 0, latched op/sign flags 0.
  - done=0, result_sel=RES_Z, result_neg=0.
  - mux_R/D/Z = KEEP, mux_multA/B = ZERO.
  - Reset mid-op abandons the op; no done.
- Outside the states below, all selects are KEEP/ZERO.
- Handshake:
  - ready=1 only in IDLE.
  - Accept when valid && ready && !flush.
  - On accept latch funct3, signedness, rs1_sign, rs2_sign, rs2_zero.
- Flush:
  - In any state, returns to IDLE next cycle with no done.
  - flush with valid in IDLE: not accepted.
- Accept cycle (IDLE, accepting):
  - MUL*/DIVU/REMU: mux_R=A, mux_D=B.
  - DIV/REM: mux_R = rs1_sign ? A_NEG : A; mux_D = rs2_sign ? B_NEG : B.
  - Division ops additionally drive mux_Z=ZERO.
- Multiply path: IDLE → MUL_OP (1) → MUL_WAIT (MULT_LATENCY+1) → MUL_CAPT (1) → DONE (1).
  - From MUL_OP through MUL_CAPT, hold the multA/multB selects:
    - MUL, MULHU: A unsigned, B unsigned.
    - MULH: A signed, B signed.
    - MULHSU: A signed, B unsigned.
  - Holding them through MUL_CAPT is mandatory: upper-word extraction depends on them.
  - MUL_CAPT: mux_R=MULT_LOWER, mux_Z=MULT_UPPER.
  - DONE: result_sel = RES_R for MUL, RES_Z otherwise; result_neg=0.
  - Default latency: accept at cycle 0, done at cycle 4.
- Divide path: IDLE → DIV_ITER (DIV_STEPS cycles, counter 0..31) → DONE.
  - DIV_ITER: mux_R=SUB_KEEP, mux_Z=SHL_ADD, mux_D=SHR.
  - Exits when counter==31; counter wraps to 0.
  - Done at cycle 33.
  - DONE result_sel: RES_Z for DIV/DIVU, RES_R for REM/REMU.
  - result_neg for DIV: rs1_sign ^ rs2_sign && !rs2_zero.
  - result_neg for REM: rs1_sign.
  - result_neg for unsigned ops: 0.
- Boundaries:
  - Divide by zero yields quotient 0xFFFFFFFF (never negated) and remainder rs1.
  - 0x80000000 / -1 yields quotient 0x80000000 and remainder 0 (signs equal, no negation).
  - DONE always returns to IDLE; a back-to-back op is accepted the cycle after done.

Optional Feature:
M_DIV_ZERO_BYPASS_EN:
- Defined: a division op accepted with rs2_zero goes to DONE directly.
  - Accept cycle drives mux_R=A (raw rs1).
  - DONE drives result_sel=RES_ONES for DIV/DIVU, RES_R for REM/REMU; result_neg=0.
  - done at cycle 1.
- Undefined: full 32-step path; RES_ONES is never produced.

Decomposition:
- Existing mux encodings stay in m_definitions.svh.
- Add to m_definitions.svh: RES_Z/RES_R/RES_ONES encodings, RESULT_SEL_LENGTH, funct3 constants, FSM state enum.
- One sub-module: m_step_counter (5-bit, clear/enable, terminal-count flag).

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD → done at cycle 4, result_sel=RES_R, datapath R=0xFFFFFFEB; MULH → Z=0xFFFFFFFF; MULHU → Z=0x00000006.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 → accept drives A_NEG/B, 32 ITER cycles, done at cycle 33, result_neg=1, Z=3 (final −3); REM same operands → RES_R, result_neg=1, R=1.
- DIVU rs2=0, rs1=0x1234 → without macro done at cycle 33, Z=0xFFFFFFFF, R=0x1234, result_neg=0; with M_DIV_ZERO_BYPASS_EN → done at cycle 1, RES_ONES.
- DIV 0x80000000 / 0xFFFFFFFF → result_neg=0, Z=0x80000000; REM → R=0.
- flush at ITER step 10 → no done, ready=1 next cycle, following MULHU accepted and completes normally.
- resetn pulsed asynchronously mid-MUL_WAIT → outputs return to reset values immediately, no done after release.
